jt7759_fetch: RTL and testbench

- Read sequencer for the jt7759 byte datapath.
- On a start command it walks the phrase table: reads the phrase count, range-checks the requested phrase and reads its 16-bit start pointer.
- It then streams consecutive ROM/FIFO bytes into a 2-entry prefetch buffer that the ADPCM decoder drains.
- It is the sole master of the datapath's ctrl_cs/ctrl_addr/ctrl_din/ctrl_ok interface.

---
 rtl/jt7759_fetch_pkg.sv | 16 +
 rtl/jt7759_fetch_fifo.sv | 52 +++++
 rtl/jt7759_fetch.sv | 158 +++++++++++++++
 tb/tb_jt7759_fetch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt7759_fetch_pkg.sv
// Shared types and constants for the jt7759 read sequencer.
package jt7759_fetch_pkg;

  localparam int unsigned AW           = 17;
  localparam int unsigned TBL_BASE_DEF = 5;

  typedef enum logic [2:0] {
    StIdle,
    StRdMax,
    StRdHi,
    StRdLo,
    StStream,
    StGap
  } state_t;

endpackage

// File: rtl/jt7759_fetch_fifo.sv
// Two-entry prefetch buffer between the read sequencer and the ADPCM decoder.
module jt7759_fetch_fifo (
  input  logic       rst,
  input  logic       clk,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  input  logic       flush,
  output logic [7:0] dout,
  output logic [1:0] count
);

  logic [7:0] tail;
  logic       pop_ok;
  logic       push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= 8'd0;
      tail  <= 8'd0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) dout <= din;
          else tail <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          dout  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new byte lands behind the old tail.
          if (count == 2'd1) begin
            dout <= din;
          end else begin
            dout <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jt7759_fetch.sv
// Phrase-table walker and byte streamer; sole master of the ctrl_* read port.
// Optional read timeout enabled by defining JT7759_TIMEOUT_EN.
module jt7759_fetch
  import jt7759_fetch_pkg::*;
#(
  parameter int unsigned TBL_BASE = TBL_BASE_DEF,
  parameter int unsigned TO_TICKS = 255
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen4,
  input  logic          start,
  input  logic [7:0]    sel,
  input  logic          stop,
  output logic          busy,
  output logic          err,
  input  logic          byte_rd,
  output logic [7:0]    byte_dout,
  output logic          byte_ok,
  output logic          ctrl_cs,
  output logic [AW-1:0] ctrl_addr,
  input  logic [7:0]    ctrl_din,
  input  logic          ctrl_ok
);

  state_t        state;
  logic [7:0]    sel_r;
  logic [7:0]    hi;
  logic [1:0]    count;
  logic          rd_done;
  logic          timeout;
  logic          flush;
  logic          push;
  logic          slot_free;
  logic [AW-1:0] tbl_addr;

  assign rd_done   = ctrl_cs && ctrl_ok;
  assign tbl_addr  = AW'(TBL_BASE) + {8'd0, sel_r, 1'b0};
  assign push      = (state == StStream) && rd_done;
  // A pop in this clk frees a slot even when the buffer is full.
  assign slot_free = (count != 2'd2) || byte_rd;
  assign flush     = start || (stop && (state != StIdle)) || timeout;
  assign byte_ok   = (count != 2'd0);

`ifdef JT7759_TIMEOUT_EN
  logic [7:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= 8'd0;
    end else if (!ctrl_cs) begin
      to_cnt <= 8'd0;
    end else if (cen4 && !ctrl_ok && (to_cnt != TO_TICKS[7:0])) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  assign timeout = ctrl_cs && !ctrl_ok && (to_cnt == TO_TICKS[7:0]);
`else
  logic unused_cfg;
  assign unused_cfg = ^{cen4, TO_TICKS[7:0]};
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      busy      <= 1'b0;
      err       <= 1'b0;
      ctrl_cs   <= 1'b0;
      ctrl_addr <= '0;
      sel_r     <= 8'd0;
      hi        <= 8'd0;
    end else if (start) begin
      sel_r     <= sel;
      busy      <= 1'b1;
      err       <= 1'b0;
      ctrl_addr <= '0;
      if (state == StIdle) begin
        state   <= StRdMax;
        ctrl_cs <= 1'b1;
      end else begin
        state   <= StGap;
        ctrl_cs <= 1'b0;
      end
    end else if (stop && (state != StIdle)) begin
      state   <= StIdle;
      busy    <= 1'b0;
      ctrl_cs <= 1'b0;
    end else if (timeout) begin
      state   <= StIdle;
      busy    <= 1'b0;
      err     <= 1'b1;
      ctrl_cs <= 1'b0;
    end else begin
      // Every capture drops ctrl_cs; the following clk re-raises it, giving the one-clk gap.
      case (state)
        StGap: begin
          state   <= StRdMax;
          ctrl_cs <= 1'b1;
        end
        StRdMax: begin
          if (rd_done) begin
            ctrl_cs <= 1'b0;
            if (sel_r > ctrl_din) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= StIdle;
            end else begin
              ctrl_addr <= tbl_addr;
              state     <= StRdHi;
            end
          end
        end
        StRdHi: begin
          if (rd_done) begin
            hi        <= ctrl_din;
            ctrl_cs   <= 1'b0;
            ctrl_addr <= tbl_addr + AW'(1);
            state     <= StRdLo;
          end else begin
            ctrl_cs <= 1'b1;
          end
        end
        StRdLo: begin
          if (rd_done) begin
            ctrl_cs   <= 1'b0;
            ctrl_addr <= {hi, ctrl_din, 1'b0};
            state     <= StStream;
          end else begin
            ctrl_cs <= 1'b1;
          end
        end
        StStream: begin
          if (rd_done) begin
            ctrl_cs   <= 1'b0;
            ctrl_addr <= ctrl_addr + AW'(1);
          end else if (!ctrl_cs && slot_free) begin
            ctrl_cs <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  jt7759_fetch_fifo u_fifo (
    .rst   (rst),
    .clk   (clk),
    .push  (push),
    .din   (ctrl_din),
    .pop   (byte_rd),
    .flush (flush),
    .dout  (byte_dout),
    .count (count)
  );

endmodule

// File: tb/tb_jt7759_fetch.sv
// Directed and randomized checks of jt7759_fetch against a ROM/responder model.
module tb_jt7759_fetch;

  logic        rst;
  logic        clk = 1'b0;
  logic        cen4;
  logic        start;
  logic [7:0]  sel;
  logic        stop;
  logic        busy;
  logic        err;
  logic        byte_rd;
  logic [7:0]  byte_dout;
  logic        byte_ok;
  logic        ctrl_cs;
  logic [16:0] ctrl_addr;
  logic [7:0]  ctrl_din;
  logic        ctrl_ok;

  logic [7:0]  rom [131072];
  logic [16:0] rd_log [$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic        stall_en = 1'b0;
  logic [16:0] stall_addr = 17'd0;
  logic        late = 1'b0;
  logic        prev_cs;

  jt7759_fetch dut (
    .rst       (rst),
    .clk       (clk),
    .cen4      (cen4),
    .start     (start),
    .sel       (sel),
    .stop      (stop),
    .busy      (busy),
    .err       (err),
    .byte_rd   (byte_rd),
    .byte_dout (byte_dout),
    .byte_ok   (byte_ok),
    .ctrl_cs   (ctrl_cs),
    .ctrl_addr (ctrl_addr),
    .ctrl_din  (ctrl_din),
    .ctrl_ok   (ctrl_ok)
  );

  always #5 clk = ~clk;

  // Datapath model: random-latency reads from rom, request log, cen4 every 4 clks.
  always @(negedge clk) begin
    cyc++;
    cen4 = (cyc % 4 == 0);
    if (rst) begin
      ctrl_ok  = 1'b0;
      ctrl_din = 8'd0;
      prev_cs  = 1'b0;
    end else begin
      if (ctrl_cs && !prev_cs) rd_log.push_back(ctrl_addr);
      prev_cs = ctrl_cs;
      if (late) begin
        ctrl_ok = 1'b1;
      end else if (!ctrl_cs) begin
        ctrl_ok = 1'b0;
      end else if (!ctrl_ok && !(stall_en && ctrl_addr == stall_addr) &&
                   $urandom_range(0, 2) != 0) begin
        ctrl_ok  = 1'b1;
        ctrl_din = rom[ctrl_addr];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] s);
    sel   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_reads(input int n, input string tag);
    int t = 0;
    while (rd_log.size() < n && t < 500) begin
      tick();
      t++;
    end
    check(tag, 32'(rd_log.size() >= n), 32'd1);
  endtask

  task automatic wait_req(input logic [16:0] a, input string tag);
    int t = 0;
    while (!(ctrl_cs && ctrl_addr == a) && t < 500) begin
      tick();
      t++;
    end
    check(tag, 32'(ctrl_cs && ctrl_addr == a), 32'd1);
  endtask

  function automatic logic [16:0] ptr_of(input logic [7:0] s);
    int t = 5 + 2 * int'(s);
    return {rom[t], rom[t+1], 1'b0};
  endfunction

  task automatic pop_one(input logic [16:0] p, inout int k, input string tag);
    int t = 0;
    logic [16:0] a;
    while (!byte_ok && t < 200) begin
      tick();
      t++;
    end
    a = p + 17'(k);
    check({tag, "_ok"}, 32'(byte_ok), 32'd1);
    check({tag, "_data"}, 32'(byte_dout), 32'(rom[a]));
    byte_rd = 1'b1;
    tick();
    byte_rd = 1'b0;
    k++;
  endtask

  initial begin
    int base;
    int k;
    int n;
    logic [16:0] p;
    logic [7:0] mx;
    logic [7:0] s;
    logic rd;

    rst = 1'b1; start = 1'b0; stop = 1'b0; byte_rd = 1'b0; sel = 8'd0;
    for (int i = 0; i < 131072; i++) rom[i] = 8'($urandom);
    rom[0] = 8'd3; rom[9] = 8'h12; rom[10] = 8'h34;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_byte_ok", 32'(byte_ok), 32'd0);
    check("rst_dout", 32'(byte_dout), 32'd0);
    check("rst_cs", 32'(ctrl_cs), 32'd0);
    check("rst_addr", 32'(ctrl_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Table walk for sel=2 then two stream prefetches, byte_ok one clk after capture.
    base = rd_log.size();
    do_start(8'd2);
    check("start_busy", 32'(busy), 32'd1);
    check("start_cs", 32'(ctrl_cs), 32'd1);
    wait_reads(base + 4, "t1_reach_stream");
    n = 0;
    while (!(ctrl_cs && ctrl_ok) && n < 200) begin tick(); n++; end
    check("t1_byte_ok_before", 32'(byte_ok), 32'd0);
    tick();
    check("t1_byte_ok_after", 32'(byte_ok), 32'd1);
    check("t1_first_byte", 32'(byte_dout), 32'(rom[17'h02468]));
    repeat (40) tick();
    check("t1_nreads", 32'(rd_log.size() - base), 32'd5);
    check("t1_cs_idle_full", 32'(ctrl_cs), 32'd0);
    if (rd_log.size() >= base + 5) begin
      check("t1_a0", 32'(rd_log[base]), 32'h0);
      check("t1_a1", 32'(rd_log[base+1]), 32'd9);
      check("t1_a2", 32'(rd_log[base+2]), 32'd10);
      check("t1_a3", 32'(rd_log[base+3]), 32'h02468);
      check("t1_a4", 32'(rd_log[base+4]), 32'h02469);
    end
    k = 0;
    pop_one(17'h02468, k, "t1_pop0");
    repeat (40) tick();
    check("t1_one_more_read", 32'(rd_log.size() - base), 32'd6);
    if (rd_log.size() >= base + 6) check("t1_a5", 32'(rd_log[base+5]), 32'h0246A);
    check("t1_second_byte", 32'(byte_dout), 32'(rom[17'h02469]));

    // Out-of-range phrase: single max read, then error and idle.
    base = rd_log.size();
    do_start(8'd4);
    check("t2_err_cleared", 32'(err), 32'd0);
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check("t2_err", 32'(err), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    repeat (20) tick();
    check("t2_nreads", 32'(rd_log.size() - base), 32'd1);
    check("t2_cs", 32'(ctrl_cs), 32'd0);

    // Pointer 0x1FFFE: stream must wrap to address 0.
    rom[0] = 8'd10; rom[19] = 8'hFF; rom[20] = 8'hFF;
    base = rd_log.size();
    do_start(8'd7);
    check("t3_err_cleared", 32'(err), 32'd0);
    k = 0;
    for (int i = 0; i < 3; i++) pop_one(17'h1FFFE, k, "t3_pop");
    wait_reads(base + 6, "t3_reads");
    if (rd_log.size() >= base + 6) begin
      check("t3_a3", 32'(rd_log[base+3]), 32'h1FFFE);
      check("t3_a4", 32'(rd_log[base+4]), 32'h1FFFF);
      check("t3_a5", 32'(rd_log[base+5]), 32'h00000);
    end

    // Randomized restarts while streaming, random pops (including pops on empty).
    for (int it = 0; it < 4; it++) begin
      mx = 8'($urandom_range(1, 255));
      s  = 8'($urandom_range(0, int'(mx)));
      rom[0] = mx;
      p = ptr_of(s);
      base = rd_log.size();
      stop = (it == 0);
      do_start(s);
      stop = 1'b0;
      check("rnd_restart_busy", 32'(busy), 32'd1);
      check("rnd_restart_gap", 32'(ctrl_cs), 32'd0);
      check("rnd_restart_flush", 32'(byte_ok), 32'd0);
      tick();
      check("rnd_restart_cs", 32'(ctrl_cs), 32'd1);
      check("rnd_restart_addr", 32'(ctrl_addr), 32'd0);
      k = 0;
      for (int c = 0; c < 300; c++) begin
        rd = 1'($urandom_range(0, 1));
        if (byte_ok) begin
          check("rnd_data", 32'(byte_dout), 32'(rom[p + 17'(k)]));
          if (rd) k++;
        end
        byte_rd = rd;
        tick();
      end
      byte_rd = 1'b0;
      check("rnd_progress", 32'(k > 0), 32'd1);
      n = rd_log.size() - base - 3;
      check("rnd_credit", 32'(n >= k && n <= k + 2), 32'd1);
      for (int i = 0; i < n; i++)
        check("rnd_addr", 32'(rd_log[base+3+i]), 32'(p + 17'(i)));
    end

    // Stop during a stalled stream read; a late ok must be ignored.
    rom[0] = 8'd5; rom[7] = 8'h00; rom[8] = 8'h40;
    stall_en = 1'b1; stall_addr = 17'h00080;
    do_start(8'd1);
    wait_req(17'h00080, "t5_stall_req");
    repeat (3) tick();
    check("t5_stalled", 32'(ctrl_ok), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_cs", 32'(ctrl_cs), 32'd0);
    check("t5_byte_ok", 32'(byte_ok), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    late = 1'b1;
    repeat (5) tick();
    late = 1'b0;
    check("t5_late_cs", 32'(ctrl_cs), 32'd0);
    check("t5_late_byte_ok", 32'(byte_ok), 32'd0);
    check("t5_late_busy", 32'(busy), 32'd0);
    check("t5_late_err", 32'(err), 32'd0);
    tick();

    // Read that never completes.
    do_start(8'd1);
    wait_req(17'h00080, "t6_stall_req");
`ifdef JT7759_TIMEOUT_EN
    n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    check("t6_err", 32'(err), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_cs", 32'(ctrl_cs), 32'd0);
    check("t6_duration", 32'(n >= 1000 && n <= 1040), 32'd1);
`else
    repeat (2000) tick();
    check("t6_still_busy", 32'(busy), 32'd1);
    check("t6_still_cs", 32'(ctrl_cs), 32'd1);
    check("t6_no_err", 32'(err), 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
`endif

    // Reset while a read is outstanding and the buffer holds a byte.
    stall_addr = 17'h00081;
    do_start(8'd1);
    wait_req(17'h00081, "t7_req");
    check("t7_prefetched", 32'(byte_ok), 32'd1);
    rst = 1'b1;
    #1;
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_err", 32'(err), 32'd0);
    check("t7_byte_ok", 32'(byte_ok), 32'd0);
    check("t7_dout", 32'(byte_dout), 32'd0);
    check("t7_cs", 32'(ctrl_cs), 32'd0);
    check("t7_addr", 32'(ctrl_addr), 32'd0);
    tick();
    rst = 1'b0;
    stall_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
